vote_sequencer: RTL and testbench

Ballot-unit controller for the voting machine. Sits between the four candidate push-buttons and the mode/LED display logic: arms one vote per presiding-officer enable, qualifies a single held button, rejects multi-button presses, owns the four saturating vote counters, and produces the one-cycle `valid_vote_casted` pulse consumed by the display controller.

---
 rtl/vote_pkg.sv | 19 +
 rtl/vote_counter.sv | 20 ++
 rtl/vote_sequencer.sv | 151 +++++++++++++++
 tb/tb_vote_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared types and helpers for the ballot-unit controller.
package vote_pkg;

  localparam int NUM_CANDIDATES = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    HOLD,
    RELEASE,
    LOCKOUT
  } state_e;

  // True when exactly one candidate button is pressed.
  function automatic logic is_onehot(input logic [NUM_CANDIDATES-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/vote_counter.sv
// Saturating vote total for one candidate; cleared only by reset.
module vote_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset)                    cnt_q <= '0;
    else if (inc && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

  assign count = cnt_q;

endmodule

// File: rtl/vote_sequencer.sv
// Ballot-unit controller: arms one vote per enable, qualifies a held single
// button, rejects multi-button presses and owns the four vote totals.
module vote_sequencer
  import vote_pkg::*;
#(
  parameter int HOLD_CYCLES    = 4,
  parameter int LOCKOUT_CYCLES = 8,
  parameter int CNT_W          = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode,
  input  logic             ballot_enable,
  input  logic [3:0]       buttons,
  output logic             ready,
  output logic             valid_vote_casted,
  output logic             invalid_vote,
  output logic [CNT_W-1:0] candidate1_vote,
  output logic [CNT_W-1:0] candidate2_vote,
  output logic [CNT_W-1:0] candidate3_vote,
  output logic [CNT_W-1:0] candidate4_vote
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

  state_e                    state_q, state_d;
  logic [HW-1:0]             hold_q, hold_d;
  logic [LW-1:0]             lock_q, lock_d;
  logic [NUM_CANDIDATES-1:0] cand_q, cand_d;
  logic                      rearm_q, rearm_d;
  logic                      ready_q, ready_d;
  logic                      valid_q, valid_d;
  logic                      invalid_q, invalid_d;
  logic                      count_inc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      lock_q    <= '0;
      cand_q    <= '0;
      rearm_q   <= 1'b0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      lock_q    <= lock_d;
      cand_q    <= cand_d;
      rearm_q   <= rearm_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      invalid_q <= invalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    lock_d    = lock_q;
    cand_d    = cand_q;
    rearm_d   = rearm_q;
    valid_d   = 1'b0;
    invalid_d = 1'b0;
    count_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mode && ballot_enable) state_d = ARMED;
      end
      ARMED: begin
        if (mode) begin
          state_d = IDLE;
        end else if (buttons == '0) begin
          state_d = ARMED;
        end else if (is_onehot(buttons)) begin
          state_d = HOLD;
          cand_d  = buttons;
          hold_d  = HW'(1);
        end else begin
          invalid_d = 1'b1;
          rearm_d   = 1'b1;
          state_d   = RELEASE;
        end
      end
      HOLD: begin
        if (mode) begin
          // Ballot is lost on a mode switch; nothing is counted.
          state_d = IDLE;
          cand_d  = '0;
        end else if (buttons == cand_q) begin
          if (hold_q == HOLD_LAST) begin
            count_inc = 1'b1;
            valid_d   = 1'b1;
            rearm_d   = 1'b0;
            state_d   = RELEASE;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end else if (buttons == '0) begin
          // Bounce or early release: ballot stays armed.
          state_d = ARMED;
        end else begin
          invalid_d = 1'b1;
          rearm_d   = 1'b1;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        if (buttons == '0) begin
          state_d = LOCKOUT;
          lock_d  = '0;
        end
      end
      LOCKOUT: begin
        if (buttons != '0) begin
          lock_d = '0;
        end else if (lock_q == LOCK_LAST) begin
          state_d = (rearm_q && !mode) ? ARMED : IDLE;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == ARMED);
  end

  logic [NUM_CANDIDATES-1:0][CNT_W-1:0] cnt;

  for (genvar i = 0; i < NUM_CANDIDATES; i++) begin : g_cnt
    vote_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (count_inc & cand_q[i]),
      .count (cnt[i])
    );
  end

  assign ready             = ready_q;
  assign valid_vote_casted = valid_q;
  assign invalid_vote      = invalid_q;
  assign candidate1_vote   = cnt[0];
  assign candidate2_vote   = cnt[1];
  assign candidate3_vote   = cnt[2];
  assign candidate4_vote   = cnt[3];

endmodule

// File: tb/tb_vote_sequencer.sv
// Directed bench for vote_sequencer with a pulse scoreboard.
module tb_vote_sequencer;

  localparam int H = 4;
  localparam int L = 8;
  localparam int W = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset, mode, ballot_enable;
  logic [3:0]   buttons;
  logic         ready, valid_vote_casted, invalid_vote;
  logic [W-1:0] c1, c2, c3, c4;

  vote_sequencer #(.HOLD_CYCLES(H), .LOCKOUT_CYCLES(L), .CNT_W(W)) dut (
    .clock             (clock),
    .reset             (reset),
    .mode              (mode),
    .ballot_enable     (ballot_enable),
    .buttons           (buttons),
    .ready             (ready),
    .valid_vote_casted (valid_vote_casted),
    .invalid_vote      (invalid_vote),
    .candidate1_vote   (c1),
    .candidate2_vote   (c2),
    .candidate3_vote   (c3),
    .candidate4_vote   (c4)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic              is_valid;
    logic [3:0][W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   exp_cnt[4];
  int   nassert = 0;
  int   nfail   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int cnt_of(input int i);
    case (i)
      0:       return int'(c1);
      1:       return int'(c2);
      2:       return int'(c3);
      default: return int'(c4);
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input bit is_valid, input int c);
    exp_t e;
    if (is_valid && exp_cnt[c] < MAXV) exp_cnt[c]++;
    e.is_valid = is_valid;
    for (int i = 0; i < 4; i++) e.cnt[i] = W'(exp_cnt[i]);
    sb.push_back(e);
  endtask

  task automatic check_counts(input string tag);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_cand%0d", tag, i + 1), cnt_of(i), exp_cnt[i]);
  endtask

  task automatic arm();
    ballot_enable = 1'b1;
    tick();
    ballot_enable = 1'b0;
  endtask

  // Full valid press of candidate c, then release and wait out the lockout.
  task automatic vote(input int c);
    push(1'b1, c);
    buttons = 4'(1 << c);
    repeat (H) tick();
    buttons = '0;
    repeat (L + 1) tick();
  endtask

  // Every pulse must match the next scoreboard entry.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && (valid_vote_casted || invalid_vote)) begin
      chk("pulse_overlap", int'(valid_vote_casted & invalid_vote), 0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", int'({valid_vote_casted, invalid_vote}), 0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", int'(valid_vote_casted), int'(e.is_valid));
        for (int i = 0; i < 4; i++)
          chk($sformatf("pulse_cand%0d", i + 1), cnt_of(i), int'(e.cnt[i]));
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    reset = 1'b1; mode = 1'b0; ballot_enable = 1'b0; buttons = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_ready", int'(ready), 0);
    chk("rst_valid", int'(valid_vote_casted), 0);
    chk("rst_invalid", int'(invalid_vote), 0);
    check_counts("rst");

    // Single valid vote for candidate 2.
    arm();
    chk("arm_ready", int'(ready), 1);
    vote(1);
    check_counts("v2");
    chk("v2_ready", int'(ready), 0);
    // Press without a new enable is ignored.
    buttons = 4'b0010;
    repeat (H) tick();
    buttons = '0;
    repeat (L + 1) tick();
    check_counts("noarm");

    // Multi-button press rejected, unit re-arms after lockout.
    arm();
    push(1'b0, 0);
    buttons = 4'b0101;
    tick();
    chk("inv_ready", int'(ready), 0);
    buttons = '0;
    repeat (L) tick();
    chk("lock_ready", int'(ready), 0);
    tick();
    chk("rearm_ready", int'(ready), 1);
    vote(2);
    check_counts("v3");

    // Early release keeps the ballot; only one increment.
    arm();
    buttons = 4'b0001;
    repeat (2) tick();
    buttons = '0;
    tick();
    chk("bounce_ready", int'(ready), 1);
    vote(0);
    check_counts("v1");

    // Saturation of candidate 4.
    for (int n = 0; n < MAXV; n++) begin
      arm();
      vote(3);
    end
    chk("sat_fill", int'(c4), MAXV);
    arm();
    vote(3);
    chk("sat_hold", int'(c4), MAXV);
    check_counts("sat");

    // Mode switch during HOLD aborts the ballot.
    arm();
    buttons = 4'b0010;
    repeat (2) tick();
    mode = 1'b1;
    tick();
    chk("abort_ready", int'(ready), 0);
    buttons = '0;
    ballot_enable = 1'b1;
    repeat (2) tick();
    chk("mode1_enable_ignored", int'(ready), 0);
    ballot_enable = 1'b0;
    mode = 1'b0;
    tick();
    chk("post_abort_ready", int'(ready), 0);
    check_counts("abort");

    // Reset during HOLD clears everything.
    arm();
    buttons = 4'b0100;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    buttons = '0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    chk("midrst_ready", int'(ready), 0);
    check_counts("midrst");
    repeat (2) tick();
    arm();
    chk("post_rst_arm", int'(ready), 1);
    vote(0);
    check_counts("post_rst");

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
